// File: rtl/z80_bus_responder.sv
// Z80 bus slave: registered memory and 256-byte I/O space, per-space wait
// states, interrupt-acknowledge vector, backdoor load port and write-log FIFO.
module z80_bus_responder #(
  parameter int unsigned MEM_AW    = 16,
  parameter int unsigned MEM_WAIT  = 0,
  parameter int unsigned IO_WAIT   = 1,
  parameter logic [7:0]  INTA_VEC  = 8'hFF,
  parameter int unsigned LOG_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 A,
  input  logic [7:0]                  dout,
  output logic [7:0]                  di,
  input  logic                        m1_n,
  input  logic                        mreq_n,
  input  logic                        iorq_n,
  input  logic                        rd_n,
  input  logic                        wr_n,
  input  logic                        rfsh_n,
  output logic                        wait_n,
  input  logic                        load_en,
  input  logic                        load_io,
  input  logic [15:0]                 load_addr,
  input  logic [7:0]                  load_data,
  output logic                        load_ack,
  output logic                        log_valid,
  input  logic                        log_ready,
  output logic                        log_io,
  output logic [15:0]                 log_addr,
  output logic [7:0]                  log_data,
  output logic [$clog2(LOG_DEPTH):0]  log_count,
  output logic                        log_overflow
);

  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
  localparam int unsigned LOG_AW    = $clog2(LOG_DEPTH);
  localparam int unsigned CNT_W     = LOG_AW + 1;
  localparam int unsigned ENT_W     = 25;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} state_e;

  logic [7:0]       mem [MEM_DEPTH];
  logic [7:0]       io  [256];
  logic [ENT_W-1:0] log_mem [LOG_DEPTH];

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             acc_prev_q, acc_prev_d;
  logic             wait_n_q, wait_n_d;
  logic             load_ack_q, load_ack_d;
  logic [LOG_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             log_valid_q, log_valid_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       mem_q, io_q;

  logic mem_acc_c, io_acc_c, inta_c, acc_c, commit_c;
  logic bus_we_c, load_we_c, push_c, pop_c, full_c;
  logic [3:0] wait_load_c;

  // Strobe decode; refresh cycles never count as memory accesses
  assign mem_acc_c   = !mreq_n && rfsh_n && (!rd_n || !wr_n);
  assign io_acc_c    = !iorq_n && m1_n && (!rd_n || !wr_n);
  assign inta_c      = !iorq_n && !m1_n;
  assign acc_c       = mem_acc_c || io_acc_c;
  assign wait_load_c = io_acc_c ? 4'(IO_WAIT) : 4'(MEM_WAIT);

  // Access sequencing: detect start, count wait states, flag the commit edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc_c && !acc_prev_q) begin
          if (wait_load_c != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = wait_load_c;
          end else begin
            state_d  = S_ACTIVE;
            commit_c = !wr_n;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d  = S_ACTIVE;
          cnt_d    = 4'd0;
          commit_c = !wr_n;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACTIVE: begin
        if (!acc_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus writes take priority over the backdoor; nothing commits under reset
  assign bus_we_c  = commit_c && !reset;
  assign load_we_c = load_en && !bus_we_c && !reset;

  // Log FIFO bookkeeping; a pop frees the slot for a same-cycle push
  assign pop_c  = log_valid_q && log_ready;
  assign full_c = (count_q == CNT_W'(LOG_DEPTH));
  assign push_c = bus_we_c && (!full_c || pop_c);

  always_comb begin
    acc_prev_d  = acc_c;
    wait_n_d    = (state_d != S_WAIT);
    load_ack_d  = load_we_c;
    wr_ptr_d    = push_c ? wr_ptr_q + LOG_AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_c  ? rd_ptr_q + LOG_AW'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    log_valid_d = (count_d != '0);
    overflow_d  = overflow_q || (bus_we_c && full_c && !pop_c);
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      acc_prev_q  <= 1'b0;
      wait_n_q    <= 1'b1;
      load_ack_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      log_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_prev_q  <= acc_prev_d;
      wait_n_q    <= wait_n_d;
      load_ack_q  <= load_ack_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      log_valid_q <= log_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Memory array: single write port shared by bus and backdoor, registered read
  always_ff @(posedge clk) begin
    if (bus_we_c && !io_acc_c)
      mem[A[MEM_AW-1:0]] <= dout;
    else if (load_we_c && !load_io)
      mem[load_addr[MEM_AW-1:0]] <= load_data;
    mem_q <= mem[A[MEM_AW-1:0]];
  end

  // I/O array: same structure over the low address byte
  always_ff @(posedge clk) begin
    if (bus_we_c && io_acc_c)
      io[A[7:0]] <= dout;
    else if (load_we_c && load_io)
      io[load_addr[7:0]] <= load_data;
    io_q <= io[A[7:0]];
  end

  // Log storage: {io, addr, data} captured on the commit edge
  always_ff @(posedge clk) begin
    if (push_c) log_mem[wr_ptr_q] <= {io_acc_c, A, dout};
  end

  assign di           = inta_c ? INTA_VEC : (!iorq_n ? io_q : mem_q);
  assign wait_n       = wait_n_q;
  assign load_ack     = load_ack_q;
  assign log_valid    = log_valid_q;
  assign log_count    = count_q;
  assign log_overflow = overflow_q;
  assign {log_io, log_addr, log_data} = log_mem[rd_ptr_q];

endmodule

// File: doc/z80_bus_responder.md
# z80_bus_responder

Parametrised, synthesizable Z80 bus slave for tv80s test systems and FPGA builds: single-cycle-registered memory and 256-byte I/O space, programmable wait-state insertion per space, interrupt-acknowledge vector, backdoor load port and a write-log FIFO.
- Replaces the ad hoc negedge memory/IO arrays around `tv80s`.
- Sits directly on the CPU pins: `A`, `dout`, `di`, strobes, `wait_n`.
- Lets benches preload programs and check every CPU write in order, with wait states.

## Interface
Parameters:
- MEM_AW, 16, memory address width; depth 2^MEM_AW, upper `A` bits ignored (aliasing)
- MEM_WAIT, 0, wait cycles inserted on each memory read/write (0..15)
- IO_WAIT, 1, wait cycles inserted on each I/O read/write (0..15)
- INTA_VEC, 8'hFF, byte driven on `di` during interrupt acknowledge
- LOG_DEPTH, 16, write-log FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- A  in  16  CPU address
- dout  in  8  CPU write data
- di  out  8  CPU read data
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU strobes, active-low
- wait_n  out  1  to CPU `wait_n`
- load_en  in  1  backdoor write request
- load_io  in  1  1 = I/O space, 0 = memory
- load_addr  in  16  backdoor address
- load_data  in  8  backdoor data
- load_ack  out  1  one-cycle pulse: backdoor write committed
- log_valid  out  1  FIFO head valid
- log_ready  in  1  pop head when `log_valid`
- log_io, log_addr[15:0], log_data[7:0]  out  FIFO head fields
- log_count  out  $clog2(LOG_DEPTH)+1  entries held
- log_overflow  out  1  sticky: a write was dropped because FIFO was full

## Operation
- Decode, combinational:
  - mem_acc = !mreq_n & rfsh_n & (!rd_n | !wr_n)
  - io_acc = !iorq_n & m1_n & (!rd_n | !wr_n)
  - inta = !iorq_n & !m1_n
  - refresh cycles (`rfsh_n`=0) are ignored
- Read path:
  - mem_q <= mem[A[MEM_AW-1:0]] and io_q <= io[A[7:0]] every clock.
  - di = inta ? INTA_VEC : (!iorq_n ? io_q : mem_q).
- FSM states: IDLE, WAIT, ACTIVE.
  - IDLE: on a rising edge of (mem_acc | io_acc), load cnt = MEM_WAIT or IO_WAIT.
    - cnt ≠ 0 → WAIT.
    - cnt = 0 → ACTIVE.
  - WAIT: cnt decrements each clock; at cnt = 1 → ACTIVE.
  - ACTIVE: when mem_acc | io_acc drops → IDLE.
- wait_n = 0 exactly while in WAIT (registered state, no combinational path from strobes).
- Write commit:
  - occurs once per access, on the clock edge entering ACTIVE with wr_n = 0.
  - target is mem or io per the access type; data = `dout` at that edge.
  - the same edge pushes {io, A, dout} to the log.
- Log FIFO:
  - push when not full; otherwise drop and set `log_overflow`.
  - pop when log_valid & log_ready.
  - push and pop in the same cycle when full: both occur, count unchanged, no overflow.
- Backdoor load:
  - committed on any edge with load_en = 1 and no bus write commit; `load_ack` = 1 next cycle.
  - if a bus write commits in the same cycle, the bus write wins; load is held off (`load_en` must stay high until `load_ack`).
  - backdoor writes are not logged.
- Reset:
  - FSM → IDLE, wait_n = 1, cnt = 0, FIFO emptied, log_overflow = 0, load_ack = 0.
  - mem/io contents and mem_q/io_q are NOT cleared.
  - reset mid-WAIT releases `wait_n` immediately (async) and abandons the access without commit.

## Timing
- Reset values: wait_n = 1, load_ack = 0, log_valid = 0, log_count = 0, log_overflow = 0.
- di = 8'hxx until the first clock after reset (array contents undefined unless loaded).
- Read latency: `di` reflects the location addressed by `A` one clock after `A` is stable.
- Wait insertion: access detected at edge k → wait_n low edges k+1..k+N → high at k+N+1.
- Write visible to a following read one clock after commit; log entry visible (`log_valid`) one clock after commit.
- `log_overflow` clears only on reset.

## Test plan
- Reset: hold reset 3 clocks → wait_n = 1, log_valid = 0, log_count = 0, log_overflow = 0.
- Backdoor load then read:
  - Stimulus: load mem[0000] = DD, mem[0001] = 60; drive mreq_n = rd_n = 0, A = 0001.
  - Required: load_ack pulses twice; di = 60 one clock later; no log entry.
- I/O write with IO_WAIT = 2:
  - Stimulus: iorq_n = wr_n = 0, A = 0x0042, dout = A5.
  - Required: wait_n low exactly 2 clocks; io[42] = A5; log head = {1, 0042, A5}.
- Interrupt acknowledge: iorq_n = m1_n = 0 → di = INTA_VEC (FF); no write, no wait.
- FIFO full:
  - Stimulus: LOG_DEPTH = 4; 5 memory writes with log_ready = 0.
  - Required: log_count = 4, log_overflow = 1, heads pop in order.
  - Stimulus: write with log_ready = 1 while full.
  - Required: count stays 4, overflow unchanged.
- Reset mid-WAIT:
  - Stimulus: MEM_WAIT = 3; assert reset during the second wait cycle of a write to 1234 = 77.
  - Required: wait_n = 1 immediately; mem[1234] unchanged; log empty.
